// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and widths for the fetch stage and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_data_w = 16;
    localparam int c_addr_w = 16;
    localparam int c_perf_w = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [c_data_w-1:0] instr;
        logic [c_addr_w-1:0] pc;
    } fetch_entry_t;

    // Saturating increment for the performance counters
    function automatic logic [c_perf_w-1:0] sat_inc(input logic [c_perf_w-1:0] v, input logic en);
        return (en && (v != '1)) ? v + c_perf_w'(1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous prefetch FIFO; flush beats push, pop allowed with push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  CNT_W   = $clog2(DEPTH) + 1,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  ENTRY_T           push_data,
    input  logic             pop,
    input  logic             flush,
    output ENTRY_T           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    ENTRY_T               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd;
    logic [c_ptr_w-1:0]   r_wr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_pop_ok;

    assign w_pop_ok = pop && (r_count != '0);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= r_wr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + c_ptr_w'(1);
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(w_pop_ok);
        end
    end

    // Storage needs no reset; validity is tracked by the count
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            r_mem[r_wr] <= push_data;
        end
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC, credit-based sequential fetch, prefetch queue, redirect kill.
//               Optional counters enabled with FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int ADDR_W      = c_addr_w,
    parameter int PC_STEP     = 1,
    parameter int QUEUE_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_stalls,
`endif
    output logic [ADDR_W-1:0] out_pc_next
);

    localparam int c_cnt_w = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_issue_pc;
    logic                r_inflight;

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_full;
    logic                w_empty;
    entry_t              w_push_data;
    entry_t              w_head;

    // Credit: queued entries plus the one outstanding read never exceed the depth
    assign w_issue = (r_state == RUN) && !redirect_valid &&
                     ((32'(w_count) + 32'(r_inflight)) < 32'(QUEUE_DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    // A response arriving in a redirect cycle is dropped by the flush
    assign w_push            = r_inflight;
    assign w_push_data.instr = imem_rdata;
    assign w_push_data.pc    = r_issue_pc;
    assign w_pop             = !w_empty && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= ADDR_W'(RESET_PC);
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                BOOT:    r_state <= RUN;
                RUN:     if (!fetch_en) r_state <= HALT;
                HALT:    if (fetch_en)  r_state <= RUN;
                default: r_state <= BOOT;
            endcase
            r_inflight <= w_issue;
            if (redirect_valid) begin
                r_pc <= redirect_target;
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(PC_STEP);
            end
            if (w_issue) begin
                r_issue_pc <= r_pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .CNT_W   (c_cnt_w),
        .ENTRY_T (entry_t)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid   = !w_empty;
    assign out_instr   = w_head.instr;
    assign out_pc      = w_head.pc;
    assign out_pc_next = w_head.pc + ADDR_W'(PC_STEP);

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(w_push && w_full && !w_pop && !redirect_valid));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_fetched   <= '0;
            r_perf_redirects <= '0;
            r_perf_stalls    <= '0;
        end else begin
            r_perf_fetched   <= sat_inc(r_perf_fetched, w_pop);
            r_perf_redirects <= sat_inc(r_perf_redirects, redirect_valid);
            r_perf_stalls    <= sat_inc(r_perf_stalls, !w_empty && !out_ready);
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_redirects = r_perf_redirects;
    assign perf_stalls    = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a 1-cycle synchronous imem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_next;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    logic [31:0] perf_stalls;
`endif

    logic [15:0] key;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_next;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched    (perf_fetched),
        .perf_redirects  (perf_redirects),
        .perf_stalls     (perf_stalls),
`endif
        .out_pc_next     (out_pc_next)
    );

    // Instruction memory: word at address a is a ^ key
    always @(posedge clock) begin
        if (imem_req) imem_rdata <= imem_addr ^ key;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        exp_t e;
        e.pc      = pc;
        e.instr   = pc ^ key;
        e.pc_next = pc + 16'd1;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head must match the next expected entry
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output_pc", 32'(out_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_pc", 32'(out_pc), 32'(e.pc));
                chk("out_instr", 32'(out_instr), 32'(e.instr));
                chk("out_pc_next", 32'(out_pc_next), 32'(e.pc_next));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Returns one cycle after release: caller is at the start of cycle 0
    task automatic reset_dut(input logic [15:0] k);
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        fetch_en        = 1'b1;
        reset           = 1'b1;
        key             = k;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic end_test(input string name);
        mid();
        chk(name, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut(16'h0000);

        // Test 1: startup latency and sequential stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(16'(i));
        for (int c = 0; c <= 6; c++) begin
            mid();
            if (c == 0) begin
                chk("t1_boot_valid", 32'(out_valid), 0);
                chk("t1_boot_req", 32'(imem_req), 0);
            end
            if (c == 1) begin
                chk("t1_first_req", 32'(imem_req), 1);
                chk("t1_first_addr", 32'(imem_addr), 0);
            end
            if (c == 2) chk("t1_c2_valid", 32'(out_valid), 0);
            if (c >= 3) chk("t1_stream_valid", 32'(out_valid), 1);
            if (c == 3) chk("t1_c3_pc", 32'(out_pc), 0);
            tick();
        end
        out_ready = 1'b0;
        end_test("t1_drained");

        // Test 2: backpressure fills the queue, credit stops requests
        reset_dut(16'h1234);
        for (int i = 0; i < 4; i++) expect_pc(16'(i));
        for (int c = 0; c <= 16; c++) begin
            if (c == 13) out_ready = 1'b1;
            mid();
            if (c == 4) chk("t2_last_req_addr", 32'(imem_addr), 3);
            if (c >= 5 && c <= 12) chk("t2_credit_req", 32'(imem_req), 0);
            if (c == 12) chk("t2_held_head_pc", 32'(out_pc), 0);
            if (c >= 12) chk("t2_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b0;
        mid();
        chk("t2_next_head_pc", 32'(out_pc), 4);
        chk("t2_drained", 32'(exp_q.size()), 0);
        tick();

        // Test 3: redirect with queue loaded and a fetch in flight
        reset_dut(16'h5A5A);
        for (int i = 0; i < 3; i++) expect_pc(16'h0040 + 16'(i));
        for (int c = 0; c <= 10; c++) begin
            if (c == 5) begin
                redirect_valid  = 1'b1;
                redirect_target = 16'h0040;
            end
            if (c == 6) begin
                redirect_valid = 1'b0;
                out_ready      = 1'b1;
            end
            mid();
            if (c == 5) chk("t3_redirect_req", 32'(imem_req), 0);
            if (c == 6) begin
                chk("t3_target_req", 32'(imem_req), 1);
                chk("t3_target_addr", 32'(imem_addr), 32'h40);
            end
            if (c == 6 || c == 7) chk("t3_flushed_valid", 32'(out_valid), 0);
            if (c == 8) begin
                chk("t3_r3_valid", 32'(out_valid), 1);
                chk("t3_r3_pc", 32'(out_pc), 32'h40);
            end
            tick();
        end
        out_ready = 1'b0;
        mid();
        chk("t3_drained", 32'(exp_q.size()), 0);
`ifdef FETCH_PERF_CNT_EN
        chk("t3_perf_fetched", perf_fetched, 3);
        chk("t3_perf_redirects", perf_redirects, 1);
        chk("t3_perf_stalls", perf_stalls, 3);
`endif
        tick();

        // Test 4: redirect during a head handshake, then a second redirect
        reset_dut(16'h0F0F);
        out_ready = 1'b1;
        expect_pc(16'h0000);
        expect_pc(16'h0001);
        expect_pc(16'h0002);
        expect_pc(16'h0020);
        expect_pc(16'h0021);
        for (int c = 0; c <= 10; c++) begin
            if (c == 5) begin
                redirect_valid  = 1'b1;
                redirect_target = 16'h0010;
            end
            if (c == 6) redirect_target = 16'h0020;
            if (c == 7) redirect_valid = 1'b0;
            mid();
            if (c == 5) chk("t4_handshake_pc", 32'(out_pc), 2);
            if (c == 6) chk("t4_second_redirect_req", 32'(imem_req), 0);
            if (c == 7) chk("t4_target_addr", 32'(imem_addr), 32'h20);
            if (c >= 6 && c <= 8) chk("t4_gap_valid", 32'(out_valid), 0);
            if (c == 9) chk("t4_first_pc", 32'(out_pc), 32'h20);
            tick();
        end
        out_ready = 1'b0;
        end_test("t4_drained");

        // Test 5: PC wrap, halt and resume
        reset_dut(16'h00FF);
        out_ready = 1'b1;
        expect_pc(16'hFFFF);
        for (int i = 0; i < 6; i++) expect_pc(16'(i));
        for (int c = 0; c <= 15; c++) begin
            if (c == 1) begin
                redirect_valid  = 1'b1;
                redirect_target = 16'hFFFF;
            end
            if (c == 2) redirect_valid = 1'b0;
            if (c == 6) fetch_en = 1'b0;
            if (c == 11) fetch_en = 1'b1;
            mid();
            if (c == 2) chk("t5_wrap_addr", 32'(imem_addr), 32'hFFFF);
            if (c == 4) chk("t5_wrap_pc_next", 32'(out_pc_next), 0);
            if (c == 5) chk("t5_wrapped_pc", 32'(out_pc), 0);
            if (c == 6) chk("t5_last_addr", 32'(imem_addr), 3);
            if (c >= 7 && c <= 11) chk("t5_halt_req", 32'(imem_req), 0);
            if (c == 9 || c == 10) chk("t5_drained_valid", 32'(out_valid), 0);
            if (c == 12) begin
                chk("t5_resume_req", 32'(imem_req), 1);
                chk("t5_resume_addr", 32'(imem_addr), 4);
            end
            if (c == 14) chk("t5_resume_pc", 32'(out_pc), 4);
            tick();
        end
        out_ready = 1'b0;
        end_test("t5_drained");

        // Test 6: reset pulse while holding valid output and an outstanding read
        reset_dut(16'hC3C3);
        for (int c = 0; c <= 4; c++) begin
            if (c == 4) reset = 1'b1;
            mid();
            if (c == 3) chk("t6_valid_before", 32'(out_valid), 1);
            tick();
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        expect_pc(16'h0000);
        expect_pc(16'h0001);
        for (int c = 0; c <= 4; c++) begin
            mid();
            if (c == 0) begin
                chk("t6_reset_valid", 32'(out_valid), 0);
                chk("t6_reset_req", 32'(imem_req), 0);
`ifdef FETCH_PERF_CNT_EN
                chk("t6_perf_fetched", perf_fetched, 0);
                chk("t6_perf_redirects", perf_redirects, 0);
                chk("t6_perf_stalls", perf_stalls, 0);
`endif
            end
            if (c == 1) chk("t6_reset_pc", 32'(imem_addr), 0);
            if (c == 2) chk("t6_stale_valid", 32'(out_valid), 0);
            if (c == 3) chk("t6_first_pc", 32'(out_pc), 0);
            tick();
        end
        out_ready = 1'b0;
        end_test("t6_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
